// File: rtl/global_defs.sv
// global_defs: shared trace/request types for the memory-request path.
package global_defs;
    localparam int ADDRESS_WIDTH = 32;
    localparam int TIME_WIDTH_DEFAULT = 64;

    typedef enum logic [1:0] {
        DATA_READ   = 2'd0,
        DATA_WRITE  = 2'd1,
        INSTR_FETCH = 2'd2
    } parsed_op_t;

    typedef struct packed {
        logic [TIME_WIDTH_DEFAULT-1:0] time_stamp;
        parsed_op_t                    opcode;
        logic [ADDRESS_WIDTH-1:0]      address;
    } trace_req_t;
endpackage

// File: rtl/request_issuer_if.sv
// request_issuer_if: parser-side request handshake plus queue-side strobe bus.
interface request_issuer_if #(
    parameter int TIME_WIDTH = global_defs::TIME_WIDTH_DEFAULT
);
    logic                                   req_valid;
    logic                                   req_ready;
    logic [TIME_WIDTH-1:0]                  req_time;
    global_defs::parsed_op_t                req_opcode;
    logic [global_defs::ADDRESS_WIDTH-1:0]  req_address;
    logic                                   trace_done;
    logic                                   queue_full;
    logic                                   queue_empty;
    logic                                   op_ready_s;
    global_defs::parsed_op_t                opcode_out;
    logic [global_defs::ADDRESS_WIDTH-1:0]  address_out;
    logic [TIME_WIDTH-1:0]                  cur_time;
    logic                                   order_err;
    logic                                   all_issued;

    modport master (
        output req_valid, req_time, req_opcode, req_address, trace_done, queue_full, queue_empty,
        input  req_ready, op_ready_s, opcode_out, address_out, cur_time, order_err, all_issued
    );
    modport slave (
        input  req_valid, req_time, req_opcode, req_address, trace_done, queue_full, queue_empty,
        output req_ready, op_ready_s, opcode_out, address_out, cur_time, order_err, all_issued
    );
endinterface

// File: rtl/issue_fifo.sv
// issue_fifo: synchronous staging FIFO with wrap-bit pointers and a head view.
module issue_fifo
    import global_defs::*;
#(
    parameter type T     = trace_req_t,
    parameter int  DEPTH = 4
) (
    input  logic CPU_clk,
    input  logic rst_n,
    input  logic push_i,
    input  logic pop_i,
    input  T     din_i,
    output T     head_o,
    output logic full_o,
    output logic empty_o,
    output logic one_o
);
    localparam int AW = $clog2(DEPTH);

    T            mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q, cnt;

    assign cnt     = wr_q - rd_q;
    assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign empty_o = wr_q == rd_q;
    assign one_o   = cnt == (AW+1)'(1);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge CPU_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + (AW+1)'(1);
            if (pop_i) rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge CPU_clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/request_issuer.sv
// request_issuer: stages time-stamped trace requests and strobes each into the queue when CPU time reaches it.
module request_issuer
    import global_defs::*;
#(
    parameter int TIME_WIDTH  = TIME_WIDTH_DEFAULT,
    parameter int STAGE_DEPTH = 4
) (
    input  logic             CPU_clk,
    input  logic             rst_n,
    request_issuer_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef struct packed {
        logic [TIME_WIDTH-1:0]    time_stamp;
        parsed_op_t               opcode;
        logic [ADDRESS_WIDTH-1:0] address;
    } req_t;

    req_t                     din, head;
    logic                     full, empty, one, push, pop, due, skip, carry;
    logic [TIME_WIDTH-1:0]    inc, time_d, time_q, prev_q;
    logic [1:0]               state_d, state_q;
    logic                     op_q, order_q;
    parsed_op_t               opc_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;

    issue_fifo #(.T(req_t), .DEPTH(STAGE_DEPTH)) u_fifo (
        .CPU_clk (CPU_clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (din),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .one_o   (one)
    );

    assign din  = '{time_stamp: bus.req_time, opcode: bus.req_opcode, address: bus.req_address};
    assign push = bus.req_valid && !full && state_q != DONE;
    assign due  = !empty && head.time_stamp <= time_q;
    // WAIT issues too, so a request that is already due strobes one edge after its push.
    assign pop  = (state_q == WAIT || state_q == ISSUE) && due && !bus.queue_full;

    // Carry out of the increment blocks a skip at the wrap point.
    assign {carry, inc} = {1'b0, time_q} + (TIME_WIDTH+1)'(1);
    assign skip   = !empty && bus.queue_empty && !carry && head.time_stamp > inc;
    assign time_d = skip ? head.time_stamp : inc;

    assign state_d = state_q == IDLE ? (push ? WAIT : bus.trace_done ? DONE : IDLE)
                   : state_q == DONE ? DONE
                   : pop             ? ((one && !push) ? IDLE : WAIT)
                   : due             ? ISSUE : WAIT;

    always_ff @(posedge CPU_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            time_q  <= '0;
            prev_q  <= '0;
            op_q    <= 1'b0;
            order_q <= 1'b0;
            opc_q   <= DATA_READ;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            op_q    <= pop;
            if (pop) begin
                opc_q  <= head.opcode;
                addr_q <= head.address;
            end
            if (push) begin
                prev_q  <= bus.req_time;
                order_q <= order_q || bus.req_time < prev_q;
            end
        end
    end

    assign bus.req_ready   = !full;
    assign bus.op_ready_s  = op_q;
    assign bus.opcode_out  = opc_q;
    assign bus.address_out = addr_q;
    assign bus.cur_time    = time_q;
    assign bus.order_err   = order_q;
    assign bus.all_issued  = state_q == DONE;
endmodule

// File: doc/request_issuer.md
# request_issuer

Transmit side of the memory-request queue's strobe interface: accepts time-stamped parsed trace requests from the trace parser and presents each one to the queue with a single-cycle `op_ready_s` strobe once simulated CPU time reaches the request's arrival time. It owns the simulation time counter and advances time directly to the next arrival when the queue is empty. It never strobes while the queue reports full. It sits between the trace parser and `queue`.

## Interface
Parameters:
- TIME_WIDTH, 64, width of CPU-cycle time stamps and `cur_time`
- STAGE_DEPTH, 4, entries in the internal staging FIFO (power of two, ≥2)

Ports:
- CPU_clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  parser presents a request
- req_ready  out  1  staging FIFO can accept (count < STAGE_DEPTH)
- req_time  in  TIME_WIDTH  request arrival time, in CPU cycles
- req_opcode  in  parsed_op_t  request opcode
- req_address  in  ADDRESS_WIDTH  request address
- trace_done  in  1  level; parser has no further requests
- queue_full  in  1  downstream queue full
- queue_empty  in  1  downstream queue holds no valid entries
- op_ready_s  out  1  one-cycle strobe; new operation on opcode_out/address_out
- opcode_out  out  parsed_op_t  opcode of strobed request
- address_out  out  ADDRESS_WIDTH  address of strobed request
- cur_time  out  TIME_WIDTH  current simulated CPU time
- order_err  out  1  sticky; a request arrived with a time earlier than its predecessor
- all_issued  out  1  sticky; trace finished and every request issued

## Operation
- Push: a request is written to the FIFO tail on a posedge where `req_valid && req_ready`.
- FIFO pointers are log2(STAGE_DEPTH)+1 bits wide; the extra MSB is a wrap bit.
  - full = low bits equal and MSBs differ.
  - empty = pointers equal.
- Push and pop in the same cycle leave the count unchanged.
- Time: `cur_time` increments by 1 each cycle.
  - Exception (skip): the FIFO head is valid, `queue_empty` is 1, and `head.time > cur_time+1`. Then `cur_time` loads `head.time` instead.
  - `cur_time` wraps modulo 2^TIME_WIDTH; no skip is taken across the wrap.
- FSM, evaluated on pre-edge values:
  - IDLE: FIFO empty.
    - → DONE if `trace_done`.
    - → WAIT on the first push.
  - WAIT: head valid, `head.time > cur_time`. Skip rule applies. → ISSUE when `head.time <= cur_time`.
  - ISSUE: head eligible.
    - If `queue_full`: no strobe; remain in ISSUE.
    - Else: register `op_ready_s=1`, `opcode_out=head.opcode`, `address_out=head.address`, and pop.
    - Next state:
      - ISSUE if the new head is also eligible (back-to-back strobes allowed).
      - WAIT if the new head is not yet due.
      - IDLE if the FIFO is now empty.
  - DONE: `all_issued=1` until reset. Time keeps counting. `req_ready` stays 1 and any push is dropped.
- Order check: on push, if `req_time` < the time of the previous accepted request, set `order_err`. The request is still issued in FIFO order; it is eligible immediately.
- At most one strobe per cycle.
- `opcode_out`/`address_out` hold their last value between strobes.

## Timing
- Reset values:
  - `op_ready_s` 0; `opcode_out` DATA_READ; `address_out` 0; `cur_time` 0.
  - `order_err` 0; `all_issued` 0; `req_ready` 1.
  - FIFO empty; state IDLE.
- Reset mid-operation discards all staged requests; no strobe in the reset cycle.
- Latency: a request pushed at edge N with `req_time <= cur_time` strobes at edge N+1 (op_ready_s high N+1→N+2), if the queue is not full.
- `queue_full` is sampled at the issuing edge. A strobe is never emitted when `queue_full` was 1 at that edge.
- Skip takes effect at the edge; the strobe follows one edge later.

## Structure
- `global_defs` already supplies `parsed_op_t` (DATA_READ=0, DATA_WRITE=1, INSTR_FETCH=2) and ADDRESS_WIDTH.
- Add to `global_defs`:
  - `TIME_WIDTH_DEFAULT`
  - `trace_req_t` struct {time, opcode, address}
- The FSM state enum stays local to the module.
- Sub-module `issue_fifo`: parameterised synchronous FIFO of `trace_req_t` with wrap-bit pointers, full/empty/head outputs.

## Test plan
- Single request, time 5, queue empty → skip to `cur_time`=5; one strobe with matching opcode/address; `all_issued` after `trace_done`.
- Three requests at time 10, 10, 10 → three consecutive-cycle strobes, in order.
- `queue_full`=1 while head is due, held 20 cycles → no strobe; strobe on the edge after it drops; no time skip while `queue_empty`=0.
- Five requests pushed with `req_valid` held → `req_ready` falls after 4; 5th accepted on the first pop cycle.
- Times 50 then 30 → `order_err`=1; second request strobes on the cycle after the first.
- Assert `rst_n` while 2 requests are staged and the head is due → outputs at reset values; no strobe; FIFO empty after release.
